// File: rtl/traffic_pkg.sv
// Shared light codes, movement indices, monitor states and
// fault codes for the T-junction lamp path.
package traffic_pkg;

  localparam logic [2:0] RED        = 3'b100;
  localparam logic [2:0] RED_YELLOW = 3'b110;
  localparam logic [2:0] GREEN      = 3'b001;
  localparam logic [2:0] YELLOW     = 3'b010;
  localparam logic [2:0] DARK       = 3'b000;

  localparam int NMOV = 6;

  typedef enum logic [2:0] {
    W_E = 3'd0,
    W_N = 3'd1,
    E_W = 3'd2,
    E_N = 3'd3,
    N_E = 3'd4,
    N_W = 3'd5
  } mov_e;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ALLRED = 2'd1,
    FLASH  = 2'd2
  } mon_state_e;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_ENC  = 2'b01;
  localparam logic [1:0] FC_SEQ  = 2'b10;
  localparam logic [1:0] FC_CONF = 2'b11;

  typedef logic [NMOV-1:0][2:0] codes_t;

  // Movements that take part in at least one active conflict pair.
  function automatic logic [NMOV-1:0] conflict_mask(
    input logic [NMOV-1:0] act
  );
    logic [NMOV-1:0] m;
    m = '0;
    if (act[W_E] && act[N_E]) begin
      m[W_E] = 1'b1;
      m[N_E] = 1'b1;
    end
    if (act[E_W] && act[W_N]) begin
      m[E_W] = 1'b1;
      m[W_N] = 1'b1;
    end
    if (act[E_W] && act[N_E]) begin
      m[E_W] = 1'b1;
      m[N_E] = 1'b1;
    end
    if (act[E_W] && act[N_W]) begin
      m[E_W] = 1'b1;
      m[N_W] = 1'b1;
    end
    if (act[W_N] && act[E_N]) begin
      m[W_N] = 1'b1;
      m[E_N] = 1'b1;
    end
    if (act[W_N] && act[N_E]) begin
      m[W_N] = 1'b1;
      m[N_E] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Per-movement check of one light code against its previous code.
// Ports: cur_i/prev_i codes, en_i gate; bad_encoding_o, bad_sequence_o, active_o.
module lamp_seq_checker
  import traffic_pkg::*;
(
  input  logic [2:0] cur_i,
  input  logic [2:0] prev_i,
  input  logic       en_i,
  output logic       bad_encoding_o,
  output logic       bad_sequence_o,
  output logic       active_o
);

  logic valid;
  logic step_ok;

  // step_ok: cur_i is the single legal successor of prev_i
  always_comb begin
    valid   = 1'b0;
    step_ok = 1'b0;
    unique case (1'b1)
      (cur_i == RED): begin
        valid   = 1'b1;
        step_ok = (prev_i == YELLOW);
      end
      (cur_i == RED_YELLOW): begin
        valid   = 1'b1;
        step_ok = (prev_i == RED);
      end
      (cur_i == GREEN): begin
        valid   = 1'b1;
        step_ok = (prev_i == RED_YELLOW);
      end
      (cur_i == YELLOW): begin
        valid   = 1'b1;
        step_ok = (prev_i == GREEN);
      end
      default: begin
        valid   = 1'b0;
        step_ok = 1'b0;
      end
    endcase
  end

  assign bad_encoding_o = en_i & ~valid;
  assign bad_sequence_o = en_i & (cur_i != prev_i) & ~step_ok;
  assign active_o       = en_i & (cur_i != RED);

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Safety stage between phase controller and lamp drivers: forwards codes,
// traps bad encodings, bad sequences and conflicts into ALLRED then FLASH.
// Ports: clk, rst (async high), in_* codes, clear_fault; lamp_*, fault,
// fault_code. Define CONFLICT_LOG_EN to add fault_mask and fault_cycle.
module lamp_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned ALLRED_CYCLES   = 50_000_000,
  parameter int unsigned FLASH_HALF      = 50_000_000,
  parameter int unsigned CONFLICT_CYCLES = 2,
  parameter int unsigned CNT_W           = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  in_w_to_e,
  input  logic [2:0]  in_w_to_n,
  input  logic [2:0]  in_e_to_w,
  input  logic [2:0]  in_e_to_n,
  input  logic [2:0]  in_n_to_e,
  input  logic [2:0]  in_n_to_w,
  input  logic        clear_fault,
  output logic [2:0]  lamp_w_to_e,
  output logic [2:0]  lamp_w_to_n,
  output logic [2:0]  lamp_e_to_w,
  output logic [2:0]  lamp_e_to_n,
  output logic [2:0]  lamp_n_to_e,
  output logic [2:0]  lamp_n_to_w,
  output logic        fault,
  output logic [1:0]  fault_code
`ifdef CONFLICT_LOG_EN
  ,
  output logic [5:0]  fault_mask,
  output logic [31:0] fault_cycle
`endif
);

  localparam int unsigned CCW = $clog2(CONFLICT_CYCLES + 1);

  codes_t           cur;
  codes_t           prev_q, prev_d;
  codes_t           lamp_q, lamp_d;
  mon_state_e       state_q, state_d;
  logic [1:0]       fc_q, fc_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             phase_q, phase_d;
  logic [CCW-1:0]   cc_q, cc_d, cc_nxt;
  logic [NMOV-1:0]  enc_v, seq_v, act_v, conf_v;
  logic             en, enc_any, seq_any, conf;
  logic             cc_hit, ar_done, fl_wrap;
  logic             clear_ok;

  assign cur = {in_n_to_w, in_n_to_e, in_e_to_n,
                in_e_to_w, in_w_to_n, in_w_to_e};

  assign en = (state_q == NORMAL);

  for (genvar i = 0; i < NMOV; i++) begin : g_chk
    lamp_seq_checker u_chk (
      .cur_i          (cur[i]),
      .prev_i         (prev_q[i]),
      .en_i           (en),
      .bad_encoding_o (enc_v[i]),
      .bad_sequence_o (seq_v[i]),
      .active_o       (act_v[i])
    );
  end

  assign enc_any  = |enc_v;
  assign seq_any  = |seq_v;
  assign conf_v   = conflict_mask(act_v);
  assign conf     = |conf_v;
  assign cc_nxt   = cc_q + CCW'(1);
  assign cc_hit   = (cc_nxt == CCW'(CONFLICT_CYCLES));
  assign ar_done  = (tmr_q == CNT_W'(ALLRED_CYCLES - 1));
  assign fl_wrap  = (tmr_q == CNT_W'(FLASH_HALF - 1));
  assign clear_ok = clear_fault & (cur == {NMOV{RED}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        if (enc_any || seq_any || (conf && cc_hit))
          state_d = ALLRED;
      end
      ALLRED: begin
        if (ar_done) state_d = FLASH;
      end
      FLASH: begin
        if (clear_ok) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  // Lamps default to RED; only clean NORMAL cycles and FLASH
  // override that, so no offending code ever reaches a lamp.
  always_comb begin
    lamp_d  = {NMOV{RED}};
    prev_d  = prev_q;
    fc_d    = fc_q;
    tmr_d   = '0;
    phase_d = 1'b0;
    cc_d    = '0;
    unique case (state_q)
      NORMAL: begin
        prev_d = cur;
        if (enc_any) begin
          fc_d = FC_ENC;
        end else if (seq_any) begin
          fc_d = FC_SEQ;
        end else if (conf) begin
          if (cc_hit) fc_d = FC_CONF;
          else        cc_d = cc_nxt;
        end else begin
          lamp_d = cur;
        end
      end
      ALLRED: begin
        if (ar_done) begin
          phase_d = 1'b1;
          lamp_d  = {NMOV{YELLOW}};
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      FLASH: begin
        if (clear_ok) begin
          prev_d = cur;
          fc_d   = FC_NONE;
        end else begin
          tmr_d   = fl_wrap ? '0 : tmr_q + CNT_W'(1);
          phase_d = fl_wrap ? ~phase_q : phase_q;
          lamp_d  = phase_d ? {NMOV{YELLOW}} : {NMOV{DARK}};
        end
      end
      default: begin
        fc_d = fc_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_q  <= {NMOV{RED}};
      prev_q  <= {NMOV{RED}};
      fc_q    <= FC_NONE;
      tmr_q   <= '0;
      phase_q <= 1'b0;
      cc_q    <= '0;
    end else begin
      lamp_q  <= lamp_d;
      prev_q  <= prev_d;
      fc_q    <= fc_d;
      tmr_q   <= tmr_d;
      phase_q <= phase_d;
      cc_q    <= cc_d;
    end
  end

  assign lamp_w_to_e = lamp_q[W_E];
  assign lamp_w_to_n = lamp_q[W_N];
  assign lamp_e_to_w = lamp_q[E_W];
  assign lamp_e_to_n = lamp_q[E_N];
  assign lamp_n_to_e = lamp_q[N_E];
  assign lamp_n_to_w = lamp_q[N_W];
  assign fault       = (state_q != NORMAL);
  assign fault_code  = fc_q;

`ifdef CONFLICT_LOG_EN
  logic [31:0]     cyc_q;
  logic [31:0]     fcyc_q, fcyc_d;
  logic [NMOV-1:0] mask_q, mask_d;

  // Mask reflects only the movements behind the recorded fault class.
  always_comb begin
    mask_d = mask_q;
    fcyc_d = fcyc_q;
    if (state_q == NORMAL && state_d == ALLRED) begin
      fcyc_d = cyc_q;
      if (enc_any)      mask_d = enc_v;
      else if (seq_any) mask_d = seq_v;
      else              mask_d = conf_v;
    end else if (state_q == FLASH && state_d == NORMAL) begin
      mask_d = '0;
      fcyc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      fcyc_q <= '0;
      mask_q <= '0;
    end else begin
      cyc_q  <= cyc_q + 32'd1;
      fcyc_q <= fcyc_d;
      mask_q <= mask_d;
    end
  end

  assign fault_mask  = mask_q;
  assign fault_cycle = fcyc_q;
`endif

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Self-checking bench for lamp_conflict_monitor: directed scenarios
// plus randomized code streams against a behavioural model.
module tb_lamp_conflict_monitor;

  localparam int AR = 4;
  localparam int FH = 3;
  localparam int CC = 2;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RY = 3'b110;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] D  = 3'b000;

  typedef logic [5:0][2:0] codes_t;

  typedef struct packed {
    int         mode;
    codes_t     lamp;
    logic [1:0] fc;
    codes_t     prev;
    int         run;
    int         t;
  } mst_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_fault = 1'b0;
  codes_t     in_v = {6{R}};
  logic [2:0] l_we, l_wn, l_ew, l_en, l_ne, l_nw;
  logic       fault;
  logic [1:0] fault_code;
  codes_t     lamps;
`ifdef CONFLICT_LOG_EN
  logic [5:0]  fmask;
  logic [31:0] fcyc;
`endif

  int n_pass  = 0;
  int n_total = 0;
  mst_t m;

  always #5 clk = ~clk;

  assign lamps = {l_nw, l_ne, l_en, l_ew, l_wn, l_we};

  lamp_conflict_monitor #(
    .ALLRED_CYCLES  (AR),
    .FLASH_HALF     (FH),
    .CONFLICT_CYCLES(CC),
    .CNT_W          (28)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_w_to_e   (in_v[0]),
    .in_w_to_n   (in_v[1]),
    .in_e_to_w   (in_v[2]),
    .in_e_to_n   (in_v[3]),
    .in_n_to_e   (in_v[4]),
    .in_n_to_w   (in_v[5]),
    .clear_fault (clear_fault),
    .lamp_w_to_e (l_we),
    .lamp_w_to_n (l_wn),
    .lamp_e_to_w (l_ew),
    .lamp_e_to_n (l_en),
    .lamp_n_to_e (l_ne),
    .lamp_n_to_w (l_nw),
    .fault       (fault),
    .fault_code  (fault_code)
`ifdef CONFLICT_LOG_EN
    ,
    .fault_mask  (fmask),
    .fault_cycle (fcyc)
`endif
  );

  function automatic bit legal(input logic [2:0] c);
    return c == R || c == RY || c == G || c == Y;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      R:       return RY;
      RY:      return G;
      G:       return Y;
      Y:       return R;
      default: return R;
    endcase
  endfunction

  function automatic bit clash(input codes_t c);
    int pa[6] = '{0, 2, 2, 2, 1, 1};
    int pb[6] = '{4, 1, 4, 5, 3, 4};
    bit hit = 0;
    for (int p = 0; p < 6; p++)
      if (c[pa[p]] != R && c[pb[p]] != R) hit = 1;
    return hit;
  endfunction

  function automatic mst_t mreset();
    mst_t s;
    s.mode = 0;
    s.lamp = {6{R}};
    s.fc   = 2'b00;
    s.prev = {6{R}};
    s.run  = 0;
    s.t    = 0;
    return s;
  endfunction

  // mode 0 normal, 1 all-red hold, 2 flashing
  function automatic mst_t mstep(input mst_t s, input codes_t in,
                                 input logic clr);
    mst_t n;
    bit enc, seq, cf;
    n = s;
    enc = 0;
    seq = 0;
    cf = 0;
    case (s.mode)
      0: begin
        for (int i = 0; i < 6; i++) begin
          if (!legal(in[i])) enc = 1;
          else if (in[i] != s.prev[i] && in[i] != succ(s.prev[i]))
            seq = 1;
        end
        cf = clash(in);
        n.prev = in;
        n.lamp = {6{R}};
        if (enc || seq) begin
          n.fc   = enc ? 2'b01 : 2'b10;
          n.mode = 1;
          n.t    = 0;
          n.run  = 0;
        end else if (cf) begin
          n.run = s.run + 1;
          if (n.run >= CC) begin
            n.fc   = 2'b11;
            n.mode = 1;
            n.t    = 0;
            n.run  = 0;
          end
        end else begin
          n.run  = 0;
          n.lamp = in;
        end
      end
      1: begin
        n.t = s.t + 1;
        if (n.t == AR) begin
          n.mode = 2;
          n.t    = 0;
          n.lamp = {6{Y}};
        end else begin
          n.lamp = {6{R}};
        end
      end
      default: begin
        if (clr && in == {6{R}}) begin
          n.mode = 0;
          n.fc   = 2'b00;
          n.prev = in;
          n.run  = 0;
          n.t    = 0;
          n.lamp = {6{R}};
        end else begin
          n.t    = s.t + 1;
          n.lamp = ((n.t / FH) % 2 == 0) ? {6{Y}} : {6{D}};
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else     m <= mstep(m, in_v, clear_fault);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model_lamps", 32'(lamps), 32'(m.lamp));
      check("model_fault", 32'(fault), 32'(m.mode != 0));
      check("model_code", 32'(fault_code), 32'(m.fc));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic recover();
    int k;
    k = 0;
    clear_fault = 1'b0;
    in_v = {6{R}};
    while (!(fault && lamps == {6{Y}}) && k < 40) begin
      tick();
      k++;
    end
    check("flash_wait", 32'(k < 40), 32'd1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("cleared", 32'(fault), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    codes_t nx;
    logic [2:0] seqv[4] = '{RY, G, Y, R};
    @(negedge clk);
    check("rst_lamps", 32'(lamps), 32'({6{R}}));
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int ph = 0; ph < 3; ph++) begin
      for (int s = 0; s < 4; s++) begin
        in_v[2*ph]   = seqv[s];
        in_v[2*ph+1] = seqv[s];
        tick();
        check("pass_lamp", 32'(lamps[2*ph]), 32'(seqv[s]));
      end
    end
    check("pass_fault", 32'(fault), 32'd0);

    in_v[0] = RY; tick();
    in_v[0] = G;  tick();
    in_v[4] = RY; tick();
    check("conf1_lamps", 32'(lamps), 32'({6{R}}));
    check("conf1_fault", 32'(fault), 32'd0);
    in_v[4] = G;  tick();
    check("conf2_fault", 32'(fault), 32'd1);
    check("conf2_code", 32'(fault_code), 32'd3);
    repeat (3) tick();
    check("allred_end", 32'(lamps), 32'({6{R}}));
    tick();
    check("flash_on", 32'(lamps), 32'({6{Y}}));
    repeat (3) tick();
    check("flash_off", 32'(lamps), 32'({6{D}}));
    repeat (3) tick();
    check("flash_on2", 32'(lamps), 32'({6{Y}}));
    clear_fault = 1'b1;
    tick();
    check("clear_ign", 32'(fault), 32'd1);
    in_v = {6{R}};
    tick();
    clear_fault = 1'b0;
    check("clear_fault", 32'(fault), 32'd0);
    check("clear_code", 32'(fault_code), 32'd0);
    check("clear_lamps", 32'(lamps), 32'({6{R}}));

    in_v[0] = RY; tick();
    in_v[0] = G;  tick();
    in_v[0] = Y;  in_v[4] = RY; tick();
    check("ovl_lamps", 32'(lamps), 32'({6{R}}));
    in_v[0] = R;  tick();
    check("ovl_fault", 32'(fault), 32'd0);
    check("ovl_resume", 32'(lamps[4]), 32'(RY));
    in_v[4] = G; tick();
    in_v[4] = Y; tick();
    in_v[4] = R; tick();

    in_v[2] = 3'b111; tick();
    check("enc_code", 32'(fault_code), 32'd1);
    check("enc_lamps", 32'(lamps), 32'({6{R}}));
    in_v = {6{R}};
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("allred_clr", 32'(fault), 32'd1);
    recover();

    in_v[1] = G; tick();
    check("seq_code", 32'(fault_code), 32'd2);
    recover();

    in_v[0] = RY; in_v[4] = RY; in_v[2] = 3'b111; tick();
    check("prio_code", 32'(fault_code), 32'd1);
    recover();

    in_v[0] = 3'b101; tick();
    begin
      int k;
      k = 0;
      while (!(fault && lamps == {6{Y}}) && k < 40) begin
        tick();
        k++;
      end
      check("rst_flash_wait", 32'(k < 40), 32'd1);
    end
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_lamps", 32'(lamps), 32'({6{R}}));
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_code", 32'(fault_code), 32'd0);
    in_v = {6{R}};
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int it = 0; it < 400; it++) begin
      nx = in_v;
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 3) == 0) nx[i] = succ(in_v[i]);
      if ($urandom_range(0, 29) == 0)
        nx[$urandom_range(0, 5)] = 3'($urandom_range(0, 7));
      clear_fault = ($urandom_range(0, 7) == 0);
      in_v = nx;
      tick();
      if (m.mode != 0) recover();
    end
    clear_fault = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lamp_conflict_monitor.md
Name: lamp_conflict_monitor

Overview:
Downstream safety stage between the T-junction phase controller and the lamp drivers. It consumes the six 3-bit movement light codes and checks every cycle for illegal encodings, illegal per-movement sequences and conflicting movements. In normal operation it forwards the codes to the lamp outputs through a register. On any fault it forces all lamps RED, then switches to flashing YELLOW, and holds that failsafe until cleared.

Parameters:
ALLRED_CYCLES, 50_000_000, cycles of all-RED hold after a fault before flashing starts (0.5 s at 100 MHz)
FLASH_HALF, 50_000_000, cycles per half-period of the flashing-yellow toggle
CONFLICT_CYCLES, 2, consecutive cycles a conflict must persist before it latches as a fault (>=1)
CNT_W, 28, width of the shared timer counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_w_to_e, in_w_to_n, in_e_to_w, in_e_to_n, in_n_to_e, in_n_to_w  in  3 each  codes from the controller
clear_fault  in  1  operator clear request, level-sampled
lamp_w_to_e, lamp_w_to_n, lamp_e_to_w, lamp_e_to_n, lamp_n_to_e, lamp_n_to_w  out  3 each  registered lamp drive
fault  out  1  high while in ALLRED or FLASH
fault_code  out  2  00 none, 01 bad encoding, 10 bad sequence, 11 conflict; latched

Behaviour:
- Codes: RED=100, RED_YELLOW=110, GREEN=001, YELLOW=010. Any other value is a bad encoding. A movement is "active" when its code is not RED.
- Reset (async): state NORMAL, all lamps RED, fault=0, fault_code=00, timer=0, conflict counter=0, prev-code registers=RED.
- Legal per-movement transitions versus the previous-cycle input: hold, R->RY, RY->G, G->Y, Y->R. Any other change is a sequence fault. Prev registers update every cycle in NORMAL only.
- Conflict pairs (both active at once): we/ne, ew/wn, ew/ne, ew/nw, wn/en, wn/ne. All other pairs are compatible.
- State NORMAL:
  - With no detection, each lamp_* takes the corresponding in_* on the next edge (1-cycle latency).
  - Any conflict present this cycle: all lamps load RED and the conflict counter increments.
  - If the conflict clears before reaching CONFLICT_CYCLES, the counter resets and pass-through resumes.
  - When the counter reaches CONFLICT_CYCLES, the block goes to ALLRED with fault_code=11.
- Encoding or sequence fault: on the next edge, state=ALLRED, lamps=RED, fault=1. No offending code is ever driven onto a lamp.
- Simultaneous faults: priority is encoding > sequence > conflict. fault_code records the highest-priority fault only and holds until it is cleared.
- State ALLRED: all lamps RED. The timer counts 0..ALLRED_CYCLES-1, then the block enters FLASH with timer=0 and phase=on.
- State FLASH:
  - All lamps YELLOW when phase=on, otherwise all lamps 000 (dark).
  - The phase toggles each time the timer wraps at FLASH_HALF-1.
- Clear: clear_fault is honoured only in FLASH and only when all six inputs equal RED. The next state is NORMAL with fault=0, fault_code=00, prev registers loaded with the current inputs, and lamps RED. clear_fault in NORMAL or ALLRED is ignored.
- Inputs are ignored for detection while in ALLRED or FLASH.
- A new fault cannot overwrite fault_code until it has been cleared.
- Timer width is CNT_W and it is compared with ==.

Optional Feature:
- Macro CONFLICT_LOG_EN.
- Defined: adds output fault_mask[5:0], one bit per movement in port order, and output fault_cycle[31:0], a free-running cycle count captured at fault entry.
  - Both are latched on entry to ALLRED with the movements involved in the fault.
  - Both are zeroed on rst and on clear.
- Undefined: neither port exists and the cycle counter is not built. Core behaviour is identical.

Decomposition:
- Shared package traffic_pkg holds:
  - the light code constants RED, RED_YELLOW, GREEN, YELLOW;
  - a movement index enum (W_E, W_N, E_W, E_N, N_E, N_W);
  - monitor state typedef NORMAL/ALLRED/FLASH;
  - fault_code constants.
- One sub-module: lamp_seq_checker, instantiated six times. It takes the current code, the previous code and an enable; it outputs bad_encoding, bad_sequence and active.

Test Plan:
1. Drive a legal 3-phase cycle (RY,G,Y,R per phase) -> lamps equal the inputs delayed 1 cycle, fault stays 0 throughout.
2. Hold in_w_to_e=GREEN and in_n_to_e=GREEN for 2 cycles -> lamps RED from the first cycle; fault=1, fault_code=11 after 2 cycles. Repeat with a 1-cycle overlap -> no fault and pass-through resumes.
3. Set in_e_to_w=3'b111 -> next edge fault=1, fault_code=01, all lamps 100. Set in_w_to_n RED->GREEN directly -> fault_code=10.
4. In the same cycle inject a bad encoding and a conflict -> fault_code=01.
5. Run with ALLRED_CYCLES=4, FLASH_HALF=3 after a fault -> 4 cycles RED, then lamps toggle 010/000 every 3 cycles. clear_fault with one input non-RED is ignored; clear_fault with all inputs RED -> NORMAL, fault=0.
6. Assert rst mid-FLASH -> immediately lamps RED, fault=0, fault_code=00, state NORMAL.
